ex_div_unit: RTL and testbench
==============================

// Module: ex_div_unit
// PURPOSE
//  Iterative RV32M divide/remainder unit in the EX stage. Executes div, divu, rem and remu.
//  Receives divctl from the EX controller. Returns its result to the EX result mux over a start/busy/valid handshake.
//  Multi-cycle: one radix-2 restoring step per clock. Divide-by-zero and signed overflow take a 1-cycle fast path.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count equals XLEN
// PORTS
//  clk       in   1     single clock; all state updates on posedge
//  rst       in   1     asynchronous, active-high reset
//  start     in   1     request; accepted only when busy==0
//  divctl    in   2     00 div, 01 divu, 10 rem, 11 remu; sampled with start
//  rs1       in   XLEN  dividend; sampled with start
//  rs2       in   XLEN  divisor; sampled with start
//  flush     in   1     abort in-flight operation (pipeline kill)
//  busy      out  1     high whenever state != IDLE
//  valid     out  1     one-cycle pulse: result is valid
//  result    out  XLEN  quotient or remainder; held until next accepted start
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, busy=0, valid=0, result=0, count=0, internal regs=0.
//  States:
//   - IDLE: start&&!busy -> CALC, or DONE on a special case.
//   - CALC: count decrements each cycle -> DONE when count hits 0.
//   - DONE -> IDLE unconditionally.
//  Accept cycle (cycle 0): latch op, sign flags, |rs1|, |rs2|.
//   - Magnitudes are taken for signed ops only; unsigned ops use raw values.
//   - Initialise remainder=0 and count=XLEN.
//  CALC: each cycle shift {rem,quo} left 1, trial-subtract divisor.
//   - Result non-negative: keep the difference and set quotient LSB=1.
//   - Otherwise: restore and set LSB=0.
//  Latency: normal op valid in cycle XLEN+1 after the accept edge (33 for XLEN=32). Special case valid in cycle 1.
//  Sign fix, applied in the CALC->DONE transition, registered into result:
//   - div: quotient negated iff sign(rs1)!=sign(rs2).
//   - rem: remainder negated iff rs1 negative.
//   - Unsigned ops: no fix.
//  Special cases, decided at accept, no iteration:
//   - rs2==0: div/divu -> all-ones; rem/remu -> rs1.
//   - div with rs1==100..0 and rs2==all-ones -> 100..0; rem in the same case -> 0.
//  Handshake:
//   - valid high exactly one cycle, in DONE; busy is also high in DONE.
//   - start while busy is ignored; no queueing.
//   - Back-to-back: next start is accepted in the cycle after DONE.
//  flush: in CALC or DONE -> IDLE next edge; valid suppressed; result keeps its old value. Ignored in IDLE.
//   - flush && start in the same IDLE cycle: start is accepted (flush targets only in-flight ops).
//  Widths: remainder accumulator is XLEN+1 bits for the trial subtract. Negation is two's complement mod 2^XLEN.
//  Reset mid-operation: immediate IDLE with outputs at reset values; no partial valid.
// STRUCTURE
//  Shared package/header:
//   - divctl encodings: DIV_OP_DIV/DIVU/REM/REMU.
//   - State encodings: ST_IDLE/ST_CALC/ST_DONE.
//   - XLEN default.
//  Sub-module div_step (combinational): one shift-subtract iteration.
//   - Inputs: rem, quo, divisor.
//   - Outputs: rem_next, quo_next.
//  FSM, counter, sign handling and special-case detection stay in ex_div_unit.
// TESTING
//  1. divu 100/7 -> result=14, valid at cycle 33, busy 1 cycles 1..33; remu 100/7 -> 2.
//  2. div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; rem 7/-2 -> 1.
//  3. div 5/0 -> 0xFFFFFFFF at cycle 1; remu 5/0 -> 5; divu 0/0 -> 0xFFFFFFFF.
//  4. div 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; rem same operands -> 0.
//  5. start with rs1=9, rs2=3 at cycle 5 of an in-flight divu 100/7 -> ignored; result=14.
//     Then flush at cycle 10 of a new op -> busy=0 next cycle, no valid, result still 14.
//  6. Assert rst at cycle 12 of a div -> busy=0, valid=0, result=0 without a clock edge.
//     Then a new divu 100/7 completes normally at cycle 33.

Source files
------------

// File: rtl/ex_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// ex_div_unit_pkg
//  Shared definitions for the iterative RV32M divide/remainder unit:
//  operand width default, divctl operation encodings, FSM state encodings
//  and small helpers that decode the operation class.
// ----------------------------------------------------------------------------
package ex_div_unit_pkg;

   localparam int DIV_XLEN = 32;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   // Bit 0 of divctl selects unsigned, bit 1 selects remainder.
   function automatic logic op_is_signed(input div_op_e op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return op[1];
   endfunction

endpackage : ex_div_unit_pkg

// File: rtl/ex_div_unit_div_step.sv
// ----------------------------------------------------------------------------
// div_step
//  One combinational radix-2 restoring division iteration.
//  Ports:
//   i_rem       current partial remainder (always < divisor, fits XLEN bits)
//   i_quo       dividend/quotient shift register
//   i_divisor   divisor magnitude
//   o_rem_next  partial remainder after shift and trial subtract
//   o_quo_next  quotient register shifted left with the new quotient bit
// ----------------------------------------------------------------------------
module div_step
   import ex_div_unit_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_rem_next,
   output logic [XLEN-1:0] o_quo_next
);

   // The shifted remainder can reach 2*divisor-1, so the trial subtract needs
   // one extra bit; its MSB is the borrow that tells us the subtract failed.
   logic [XLEN:0] w_shift_rem;
   logic [XLEN:0] w_diff;
   logic          w_borrow;

   assign w_shift_rem = {i_rem, i_quo[XLEN-1]};
   assign w_diff      = w_shift_rem - {1'b0, i_divisor};
   assign w_borrow    = w_diff[XLEN];

   assign o_rem_next = w_borrow ? w_shift_rem[XLEN-1:0] : w_diff[XLEN-1:0];
   assign o_quo_next = {i_quo[XLEN-2:0], ~w_borrow};

endmodule : div_step

// File: rtl/ex_div_unit.sv
// ----------------------------------------------------------------------------
// ex_div_unit
//  Iterative RV32M div/divu/rem/remu unit for the EX stage. One restoring
//  step per clock (XLEN steps), with a one-cycle fast path for divide-by-zero
//  and signed overflow.
//  Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      request, accepted only in IDLE
//   divctl     operation (div/divu/rem/remu), sampled with start
//   rs1, rs2   dividend and divisor, sampled with start
//   flush      kills an in-flight operation (ignored in IDLE)
//   busy       high in CALC and DONE
//   valid      one-cycle result strobe in DONE
//   result     quotient/remainder; holds the last delivered value
// ----------------------------------------------------------------------------
module ex_div_unit
   import ex_div_unit_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      divctl,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result
);

   localparam int              CW      = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      r_state;
   div_state_e      w_state_next;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_divisor;
   logic            r_is_rem;
   logic            r_neg;       // negate the final result
   logic [XLEN-1:0] r_pending;   // value presented while in DONE
   logic [XLEN-1:0] r_result;    // last delivered value

   div_op_e         w_op;
   logic            w_signed;
   logic            w_is_rem;
   logic            w_div_zero;
   logic            w_overflow;
   logic            w_special;
   logic [XLEN-1:0] w_special_val;
   logic [XLEN-1:0] w_mag1;
   logic [XLEN-1:0] w_mag2;
   logic [XLEN-1:0] w_rem_next;
   logic [XLEN-1:0] w_quo_next;
   logic [XLEN-1:0] w_raw;
   logic [XLEN-1:0] w_fixed;

   // ---------------- accept-time decode ----------------
   assign w_op       = div_op_e'(divctl);
   assign w_signed   = op_is_signed(w_op);
   assign w_is_rem   = op_is_rem(w_op);
   assign w_div_zero = (rs2 == '0);
   assign w_overflow = w_signed && (rs1 == MIN_INT) && (rs2 == '1);
   assign w_special  = w_div_zero || w_overflow;

   // Divide-by-zero wins; the two conditions cannot coincide anyway.
   assign w_special_val = w_div_zero ? (w_is_rem ? rs1 : '1)
                                     : (w_is_rem ? '0  : rs1);

   assign w_mag1 = (w_signed && rs1[XLEN-1]) ? -rs1 : rs1;
   assign w_mag2 = (w_signed && rs2[XLEN-1]) ? -rs2 : rs2;

   // ---------------- iteration datapath ----------------
   div_step #(.XLEN(XLEN)) u_step (
      .i_rem      (r_rem),
      .i_quo      (r_quo),
      .i_divisor  (r_divisor),
      .o_rem_next (w_rem_next),
      .o_quo_next (w_quo_next)
   );

   // Sign fix uses the step outputs so the last iteration and the fix land
   // in the same CALC->DONE edge.
   assign w_raw   = r_is_rem ? w_rem_next : w_quo_next;
   assign w_fixed = r_neg ? -w_raw : w_raw;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start)          w_state_next = w_special ? ST_DONE : ST_CALC;
         ST_CALC: if (flush)          w_state_next = ST_IDLE;
                  else if (r_count == CW'(1)) w_state_next = ST_DONE;
         ST_DONE:                     w_state_next = ST_IDLE;
         default:                     w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_is_rem  <= 1'b0;
         r_neg     <= 1'b0;
         r_pending <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_is_rem  <= w_is_rem;
                  // Quotient sign differs from dividend sign only for div.
                  r_neg     <= w_signed && (w_is_rem ? rs1[XLEN-1]
                                                    : (rs1[XLEN-1] ^ rs2[XLEN-1]));
                  r_quo     <= w_mag1;
                  r_divisor <= w_mag2;
                  r_rem     <= '0;
                  r_count   <= CW'(XLEN);
                  if (w_special) r_pending <= w_special_val;
               end
            end
            ST_CALC: begin
               r_rem   <= w_rem_next;
               r_quo   <= w_quo_next;
               r_count <= r_count - 1'b1;
               if (r_count == CW'(1)) r_pending <= w_fixed;
            end
            ST_DONE: begin
               // A flushed result is never committed.
               if (!flush) r_result <= r_pending;
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign busy   = (r_state != ST_IDLE);
   assign valid  = (r_state == ST_DONE) && !flush;
   assign result = valid ? r_pending : r_result;

endmodule : ex_div_unit

// File: tb/tb_ex_div_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_div_unit
//  Self-checking bench for ex_div_unit: directed cases, handshake/flush/reset
//  behaviour and randomized operations against an arithmetic reference model.
//  Expected results go into a scoreboard queue; a monitor pops on each valid.
// ----------------------------------------------------------------------------
module tb_ex_div_unit;

   localparam int XLEN = 32;
   localparam int LAT_NORMAL  = 33;
   localparam int LAT_SPECIAL = 1;
   localparam int IDLE_BUDGET = 200;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [1:0]      divctl = 2'b00;
   logic [XLEN-1:0] rs1 = '0;
   logic [XLEN-1:0] rs2 = '0;
   logic            flush = 1'b0;
   logic            busy;
   logic            valid;
   logic [XLEN-1:0] result;

   ex_div_unit #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .divctl (divctl),
      .rs1    (rs1),
      .rs2    (rs2),
      .flush  (flush),
      .busy   (busy),
      .valid  (valid),
      .result (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [XLEN-1:0] res;
      int              issue_cyc;
      int              lat;
   } exp_t;

   exp_t            sb_q[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   logic [XLEN-1:0] last_exp = '0;

   task automatic check(input string name, input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain signed/unsigned arithmetic plus RISC-V special rules.
   function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         2'b00:   if (b == 0) return '1; else if (ovf) return a;
                  else return $signed(a) / $signed(b);
         2'b01:   if (b == 0) return '1; else return a / b;
         2'b10:   if (b == 0) return a; else if (ovf) return '0;
                  else return $signed(a) % $signed(b);
         default: if (b == 0) return a; else return a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] op,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
      if (b == 0) return LAT_SPECIAL;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
      return LAT_NORMAL;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst && valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid with result 0x%08h, required no valid (t=%0t)",
                     result, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("latency", XLEN'(cyc - e.issue_cyc), XLEN'(e.lat));
         end
      end
   end

   // ---------------- driver helpers (called at a negedge) ----------------
   task automatic wait_idle();
      int n = 0;
      while ((busy || sb_q.size() != 0) && n < IDLE_BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= IDLE_BUDGET) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d after %0d cycles, required idle",
                  busy, sb_q.size(), n);
         sb_q.delete();
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input bit push,
                        input logic [XLEN-1:0] exp, input int lat);
      exp_t e;
      wait_idle();
      start  = 1'b1;
      divctl = op;
      rs1    = a;
      rs2    = b;
      if (push) begin
         e.res = exp; e.issue_cyc = cyc; e.lat = lat;
         sb_q.push_back(e);
         last_exp = exp;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b);
      issue(op, a, b, 1'b1, model(op, a, b), model_lat(op, a, b));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0]      r_op;
      logic [XLEN-1:0] ra, rb;

      repeat (3) @(negedge clk);
      check("reset_busy",   XLEN'(busy),  '0);
      check("reset_valid",  XLEN'(valid), '0);
      check("reset_result", result,       '0);
      rst = 1'b0;
      @(negedge clk);

      // 1. divu 100/7 with busy profile, then remu 100/7
      issue(2'b01, 100, 7, 1'b1, 14, LAT_NORMAL);
      for (int k = 1; k <= LAT_NORMAL; k++) begin
         check("busy_during_op", XLEN'(busy), 1);
         @(negedge clk);
      end
      check("busy_after_op", XLEN'(busy), 0);
      issue(2'b11, 100, 7, 1'b1, 2, LAT_NORMAL);

      // 2. signed division/remainder sign rules
      issue(2'b00, -7, 2, 1'b1, 32'hFFFF_FFFD, LAT_NORMAL);
      issue(2'b10, -7, 2, 1'b1, 32'hFFFF_FFFF, LAT_NORMAL);
      issue(2'b10, 7, -2, 1'b1, 1, LAT_NORMAL);

      // 3. divide by zero fast path
      issue(2'b00, 5, 0, 1'b1, 32'hFFFF_FFFF, LAT_SPECIAL);
      issue(2'b11, 5, 0, 1'b1, 5, LAT_SPECIAL);
      issue(2'b01, 0, 0, 1'b1, 32'hFFFF_FFFF, LAT_SPECIAL);

      // 4. signed overflow fast path
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, LAT_SPECIAL);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, LAT_SPECIAL);

      // 5a. start while busy is ignored
      issue(2'b01, 100, 7, 1'b1, 14, LAT_NORMAL);
      repeat (4) @(negedge clk);
      start = 1'b1; divctl = 2'b01; rs1 = 9; rs2 = 3;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("result_held_after_ignored_start", result, 14);

      // 5b. flush in CALC: no valid, result keeps old value
      issue(2'b01, 200, 3, 1'b0, 0, 0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      check("flush_calc_valid", XLEN'(valid), 0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_calc_busy", XLEN'(busy), 0);
      check("flush_calc_result", result, 14);
      repeat (40) @(negedge clk);
      check("flush_calc_result_later", result, 14);

      // 5c. flush in DONE of a fast-path op: valid suppressed, result kept
      issue(2'b00, 5, 0, 1'b0, 0, 0);
      flush = 1'b1;
      #1;
      check("flush_done_valid", XLEN'(valid), 0);
      check("flush_done_result", result, 14);
      @(negedge clk);
      flush = 1'b0;
      check("flush_done_busy", XLEN'(busy), 0);
      repeat (2) @(negedge clk);
      check("flush_done_result_later", result, 14);

      // 5d. flush together with start in IDLE: start wins
      flush = 1'b1;
      issue(2'b11, 100, 7, 1'b1, 2, LAT_NORMAL);
      flush = 1'b0;
      wait_idle();

      // 6. asynchronous reset mid-operation, then a normal op
      issue(2'b00, 1000, -3, 1'b0, 0, 0);
      repeat (11) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy",   XLEN'(busy),  0);
      check("async_rst_valid",  XLEN'(valid), 0);
      check("async_rst_result", result,       0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(2'b01, 100, 7, 1'b1, 14, LAT_NORMAL);

      // Randomized operations, back-to-back where the DUT allows
      for (int i = 0; i < 150; i++) begin
         r_op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: begin ra = $urandom_range(0, 1000);   rb = $urandom_range(1, 50); end
            1: begin ra = $urandom;                  rb = 0; end
            2: begin ra = 32'h8000_0000;             rb = 32'hFFFF_FFFF; end
            3: begin ra = $urandom;                  rb = $urandom; end
            4: begin ra = $urandom;                  rb = XLEN'($signed($urandom_range(0, 16)) - 8); end
            default: begin ra = -XLEN'($urandom_range(0, 5000)); rb = $urandom_range(1, 99); end
         endcase
         issue_model(r_op, ra, rb);
         if (i % 10 == 0) begin
            wait_idle();
            check("result_held_random", result, last_exp);
         end
      end

      wait_idle();
      check("scoreboard_drained", XLEN'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global watchdog: keeps the run bounded even if a task stalls.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_ex_div_unit
